// File: rtl/seg_display_scheduler.sv
// Round-robin time-slicer for the 4-digit seven-segment display: picks one of
// NUM_SRC debug taps, converts it to BCD with a serial double-dabble, clamps >9999.
module seg_display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC*14-1:0] src_value,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  hold,
  input  logic                  next_btn,
  output logic [3:0]            data_0,
  output logic [3:0]            data_1,
  output logic [3:0]            data_2,
  output logic [3:0]            data_3,
  output logic [1:0]            cur_src,
  output logic                  busy,
  output logic                  overflow
);

  // Handshake: none; src_valid is a level qualifier, next_btn a one-cycle pulse.
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  cur_q, cur_d;
  logic        pending_q, pending_d;
  logic        stale_q, stale_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic [13:0] last_q, last_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  iter_q, iter_d;

  logic        expire;
  logic        advance;
  logic [3:0][13:0] vals;
  logic [3:0]  valid4;
  logic [13:0] cur_value;
  logic        cur_valid;
  logic        found;
  logic [1:0]  next_src;
  logic [2:0]  cand;
  logic [15:0] bcd_adj;

  always_comb begin
    expire = 1'b0;
    cnt_d  = cnt_q;
    if (!hold) begin
      if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (next_btn) cnt_d = '0;
    advance = expire | next_btn;
  end

  // Search cur+1, cur+2, ... wrapping, with cur itself last; smallest offset wins.
  always_comb begin
    vals                = '0;
    vals[NUM_SRC-1:0]   = src_value;
    valid4              = '0;
    valid4[NUM_SRC-1:0] = src_valid;
    cur_value = vals[cur_q];
    cur_valid = valid4[cur_q];
    found     = 1'b0;
    next_src  = cur_q;
    cand      = '0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      cand = {1'b0, cur_q} + 3'(off);
      if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
      if (valid4[cand[1:0]]) begin
        found    = 1'b1;
        next_src = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pending_d = pending_q;
    stale_d   = stale_q;
    last_d    = last_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    disp_d    = disp_q;
    bcd_adj   = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    if (state_q != IDLE && advance) pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (advance || pending_q) begin
          pending_d = 1'b0;
          if (found) begin
            cur_d   = next_src;
            stale_d = 1'b1;
          end
        end else if (cur_valid && (stale_q || cur_value != last_q)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bin_d   = cur_value;
        last_d  = cur_value;
        stale_d = 1'b0;
        bcd_d   = '0;
        iter_d  = 4'd13;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (iter_q == 4'd0) state_d = DONE;
        else                iter_d  = iter_q - 4'd1;
      end
      DONE: begin
        // Clamp is judged on the captured binary, the BCD has lost its 5th digit.
        if (last_q > 14'd9999) begin
          disp_d = 16'h9999;
          ovf_d  = 1'b1;
        end else begin
          disp_d = bcd_q;
          ovf_d  = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      pending_q <= 1'b0;
      stale_q   <= 1'b1;
      last_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      last_q    <= last_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
    end
  end

  assign data_0   = disp_q[3:0];
  assign data_1   = disp_q[7:4];
  assign data_2   = disp_q[11:8];
  assign data_3   = disp_q[15:12];
  assign cur_src  = cur_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
